// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with byte-enable writes, write-to-read bypass,
// a per-register busy scoreboard and a sequential full-file clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   ra_idx,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       w_idx,
    input  logic [DATA_W-1:0]       w_data,
    input  logic [DATA_W/8-1:0]     w_be,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_idx,
    input  logic                    clr_req,
    output logic                    clr_busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]    sb_q, sb_d;
    logic [DATA_W-1:0]   w_merge;
    logic                w_acc, r_acc;

    // rst in these terms also disables bypass while reset is held
    assign w_acc    = rst && we && state_q == IDLE && (ZERO_REG == 0 || w_idx != '0);
    assign r_acc    = rst && rsv_valid && state_q == IDLE && (ZERO_REG == 0 || rsv_idx != '0);
    assign clr_busy = state_q == CLEAR;

    always_comb begin
        w_merge = regs_q[w_idx];
        for (int b = 0; b < NB; b++)
            if (w_be[b]) w_merge[b*8 +: 8] = w_data[b*8 +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        sb_d    = sb_q;
        if (state_q == IDLE) begin
            if (w_acc) begin
                regs_d[w_idx] = w_merge;
                sb_d[w_idx]   = 1'b0;
            end
            // reservation applied last so it wins over a same-index write
            if (r_acc) sb_d[rsv_idx] = 1'b1;
            if (clr_req) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end else begin
            regs_d[cnt_q[ADDR_W-1:0]] = '0;
            sb_d[cnt_q[ADDR_W-1:0]]   = 1'b0;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == (ADDR_W+1)'(DEPTH-1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sb_q    <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sb_q    <= sb_d;
            regs_q  <= regs_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              z;
        assign a = ra_idx[k*ADDR_W +: ADDR_W];
        assign z = ZERO_REG != 0 && a == '0;
        assign rd_data[k*DATA_W +: DATA_W] = z ? '0 : (w_acc && w_idx == a) ? w_merge : regs_q[a];
        assign rd_busy[k] = !z && sb_q[a];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp in default, ZERO_REG=0 and wide/shallow/4-port builds.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_ok  = 0;
    int n;

    logic [9:0]   ra_a;  logic [63:0]  rd_a;  logic [1:0] bz_a;
    logic         we_a;  logic [4:0]   wi_a;  logic [31:0] wd_a; logic [3:0] be_a;
    logic         rv_a;  logic [4:0]   ri_a;  logic cr_a, cb_a;

    logic [9:0]   ra_b;  logic [63:0]  rd_b;  logic [1:0] bz_b;
    logic         we_b;  logic [4:0]   wi_b;  logic [31:0] wd_b; logic [3:0] be_b;
    logic         rv_b;  logic [4:0]   ri_b;  logic cr_b, cb_b;

    logic [11:0]  ra_c;  logic [255:0] rd_c;  logic [3:0] bz_c;
    logic         we_c;  logic [2:0]   wi_c;  logic [63:0] wd_c; logic [7:0] be_c;
    logic         rv_c;  logic [2:0]   ri_c;  logic cr_c, cb_c;

    regfile_mp u_a (
        .clk(clk), .rst(rst), .ra_idx(ra_a), .rd_data(rd_a), .rd_busy(bz_a),
        .we(we_a), .w_idx(wi_a), .w_data(wd_a), .w_be(be_a),
        .rsv_valid(rv_a), .rsv_idx(ri_a), .clr_req(cr_a), .clr_busy(cb_a)
    );

    regfile_mp #(.ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst), .ra_idx(ra_b), .rd_data(rd_b), .rd_busy(bz_b),
        .we(we_b), .w_idx(wi_b), .w_data(wd_b), .w_be(be_b),
        .rsv_valid(rv_b), .rsv_idx(ri_b), .clr_req(cr_b), .clr_busy(cb_b)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(3), .NRD(4)) u_c (
        .clk(clk), .rst(rst), .ra_idx(ra_c), .rd_data(rd_c), .rd_busy(bz_c),
        .we(we_c), .w_idx(wi_c), .w_data(wd_c), .w_be(be_c),
        .rsv_valid(rv_c), .rsv_idx(ri_c), .clr_req(cr_c), .clr_busy(cb_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [4:0] i, input logic [31:0] d, input logic [3:0] be);
        we_a = 1'b1; wi_a = i; wd_a = d; be_a = be;
        step;
        we_a = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        {ra_a, we_a, wi_a, wd_a, be_a, rv_a, ri_a, cr_a} = '0;
        {ra_b, we_b, wi_b, wd_b, be_b, rv_b, ri_b, cr_b} = '0;
        {ra_c, we_c, wi_c, wd_c, be_c, rv_c, ri_c, cr_c} = '0;
        step;
        step;
        ra_a = {5'd0, 5'd5};
        #1;
        chk("rst_rd", rd_a[31:0], 0);
        chk("rst_busy", bz_a, 0);
        chk("rst_clr", cb_a, 0);
        rst = 1'b1;

        wr_a(5, 32'h11223344, 4'hF);
        we_a = 1'b1; wi_a = 5; wd_a = 32'hAABBCCDD; be_a = 4'h5; ra_a = {5'd5, 5'd0};
        #1;
        chk("byp_p1", rd_a[63:32], 32'h11BB33DD);
        chk("byp_r0", rd_a[31:0], 0);
        step;
        we_a = 1'b0;
        #1;
        chk("bw_r5", rd_a[63:32], 32'h11BB33DD);

        we_a = 1'b1; wi_a = 0; wd_a = 32'hFFFFFFFF; be_a = 4'hF; rv_a = 1'b1; ri_a = 0; ra_a = '0;
        we_b = 1'b1; wi_b = 0; wd_b = 32'hFFFFFFFF; be_b = 4'hF; rv_b = 1'b1; ri_b = 0; ra_b = '0;
        #1;
        chk("z_byp", rd_a[31:0], 0);
        chk("nz_byp", rd_b[31:0], 32'hFFFFFFFF);
        step;
        {we_a, rv_a, we_b, rv_b} = '0;
        #1;
        chk("z_rd", rd_a[31:0], 0);
        chk("z_busy", bz_a[0], 0);
        chk("nz_rd", rd_b[31:0], 32'hFFFFFFFF);
        chk("nz_busy", bz_b[0], 1);

        rv_a = 1'b1; ri_a = 7; ra_a = {5'd9, 5'd7};
        #1;
        chk("sb_nobyp", bz_a[0], 0);
        step;
        rv_a = 1'b0;
        #1;
        chk("sb_set", bz_a[0], 1);
        we_a = 1'b1; wi_a = 7; wd_a = 32'h77; be_a = 4'hF;
        #1;
        chk("sb_hold", bz_a[0], 1);
        chk("w7_byp", rd_a[31:0], 32'h77);
        step;
        we_a = 1'b0;
        #1;
        chk("sb_clr", bz_a[0], 0);
        rv_a = 1'b1; ri_a = 7;
        step;
        rv_a = 1'b0; we_a = 1'b1; wi_a = 7; wd_a = 32'hFFFFFFFF; be_a = 4'h0;
        #1;
        chk("be0_byp", rd_a[31:0], 32'h77);
        step;
        we_a = 1'b0;
        #1;
        chk("be0_data", rd_a[31:0], 32'h77);
        chk("be0_clr", bz_a[0], 0);
        rv_a = 1'b1; ri_a = 9; we_a = 1'b1; wi_a = 9; wd_a = 32'h99; be_a = 4'hF;
        step;
        {rv_a, we_a} = '0;
        #1;
        chk("rw_busy", bz_a[1], 1);
        chk("rw_data", rd_a[63:32], 32'h99);

        for (int i = 1; i < 32; i++) wr_a(5'(i), 32'(i), 4'hF);
        ra_a = {5'd1, 5'd3}; cr_a = 1'b1;
        step;
        cr_a = 1'b0;
        n = 0;
        while (cb_a && n < 100) begin
            if (n == 0) begin
                we_a = 1'b1; wi_a = 3; wd_a = 32'hDEAD; be_a = 4'hF;
                #1;
                chk("sw_nobyp", rd_a[31:0], 3);
            end
            if (n == 1) begin
                we_a = 1'b0;
                chk("sw_drop", rd_a[31:0], 3);
            end
            if (n == 5) begin rv_a = 1'b1; ri_a = 1; end
            if (n == 6) rv_a = 1'b0;
            if (n == 10) cr_a = 1'b1;
            if (n == 11) cr_a = 1'b0;
            n++;
            step;
        end
        chk("sw_len", n, 32);
        for (int i = 0; i < 32; i++) begin
            ra_a[4:0] = 5'(i);
            #1;
            chk("sw_rd", rd_a[31:0], 0);
            chk("sw_busy", bz_a[0], 0);
        end

        wr_a(20, 32'h20, 4'hF);
        rv_a = 1'b1; ri_a = 20;
        step;
        rv_a = 1'b0; ra_a = {5'd20, 5'd20}; cr_a = 1'b1;
        step;
        cr_a = 1'b0;
        repeat (10) step;
        chk("mid_busy", cb_a, 1);
        chk("mid_old", rd_a[31:0], 32'h20);
        chk("mid_sb", bz_a[0], 1);
        rst = 1'b0; we_a = 1'b1; wi_a = 20; wd_a = 32'hFF; be_a = 4'hF;
        #1;
        chk("rst_nobyp", rd_a[31:0], 32'h20);
        step;
        chk("rst_cb", cb_a, 0);
        chk("rst_r20", rd_a[31:0], 0);
        chk("rst_sb", bz_a[0], 0);
        we_a = 1'b0; rst = 1'b1;
        wr_a(4, 32'h5, 4'hF);
        ra_a[4:0] = 4;
        #1;
        chk("post_r4", rd_a[31:0], 32'h5);

        for (int i = 0; i < 8; i++) begin
            we_c = 1'b1; wi_c = 3'(i); wd_c = 64'h0123456789ABCD00 + 64'(i); be_c = '1;
            step;
            we_c = 1'b0;
        end
        ra_c = {3'd7, 3'd5, 3'd2, 3'd0};
        #1;
        chk("c_p0", rd_c[63:0], 0);
        chk("c_p1", rd_c[127:64], 64'h0123456789ABCD02);
        chk("c_p2", rd_c[191:128], 64'h0123456789ABCD05);
        chk("c_p3", rd_c[255:192], 64'h0123456789ABCD07);
        we_c = 1'b1; wi_c = 5; wd_c = '1; be_c = 8'h81;
        #1;
        chk("c_byp", rd_c[191:128], 64'hFF23456789ABCDFF);
        step;
        we_c = 1'b0;
        #1;
        chk("c_bw", rd_c[191:128], 64'hFF23456789ABCDFF);
        cr_c = 1'b1;
        step;
        cr_c = 1'b0;
        n = 0;
        while (cb_c && n < 100) begin
            n++;
            step;
        end
        chk("c_len", n, 8);
        chk("c_clr", rd_c[255:192], 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 5, index width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; 1 = index 0 reads zero, is never written and is never busy.
REQ-005 The block SHALL have one clock; reset is synchronous and active-low.
REQ-006 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-low reset.
REQ-008 The block SHALL have port ra_idx, input, NRD*ADDR_W bits, read indices; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port rd_data, output, NRD*DATA_W bits, read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-010 The block SHALL have port rd_busy, output, NRD bits, scoreboard bit of each read port's indexed register.
REQ-011 The block SHALL have port we, input, 1 bit, write enable.
REQ-012 The block SHALL have port w_idx, input, ADDR_W bits, write index.
REQ-013 The block SHALL have port w_data, input, DATA_W bits, write data.
REQ-014 The block SHALL have port w_be, input, DATA_W/8 bits, byte enables for the write.
REQ-015 The block SHALL have port rsv_valid, input, 1 bit, reserve request: marks a register busy.
REQ-016 The block SHALL have port rsv_idx, input, ADDR_W bits, index to reserve.
REQ-017 The block SHALL have port clr_req, input, 1 bit, starts a full-file clear sweep.
REQ-018 The block SHALL have port clr_busy, output, 1 bit, high while the clear sweep runs.

Function
REQ-019 Reads SHALL be combinational with zero latency: rd_data[k] = reg[ra_idx[k]].
REQ-020 Bypass: if we=1, w_idx==ra_idx[k] and the write is accepted, rd_data[k] SHALL return a per-byte merge, using w_data bytes where w_be=1 and stored bytes elsewhere.
REQ-021 With ZERO_REG=1, a read of index 0 SHALL return 0 and rd_busy SHALL be 0, with no bypass.
REQ-022 A write is accepted when we=1, state=IDLE and (ZERO_REG=0 or w_idx!=0); on the next clk edge only the enabled bytes of reg[w_idx] SHALL update.
REQ-023 w_be of all zeros SHALL leave data unchanged but still counts as an accepted write for the scoreboard.
REQ-024 Scoreboard: each register SHALL have one busy bit; an accepted rsv_valid sets sb[rsv_idx], and an accepted write clears sb[w_idx], both at the next edge.
REQ-025 A reservation and a write to the same index in the same cycle SHALL leave the busy bit set, because the reservation wins.
REQ-026 rsv_valid SHALL be ignored when state=CLEAR or when (ZERO_REG=1 and rsv_idx==0).
REQ-027 rd_busy[k] SHALL show the registered sb[ra_idx[k]] with no bypass of same-cycle set or clear.
REQ-028 FSM states SHALL be IDLE and CLEAR, where IDLE goes to CLEAR on clr_req=1 and a sweep counter cnt is loaded with 0.
REQ-029 In CLEAR, each cycle SHALL set reg[cnt] to 0 and sb[cnt] to 0, then increment cnt; after cnt = DEPTH-1 is processed, the state SHALL return to IDLE.
REQ-030 A sweep SHALL take exactly DEPTH cycles, and clr_busy SHALL be 1 for exactly those DEPTH cycles, starting the cycle after clr_req is sampled.
REQ-031 In CLEAR, writes, reservations and clr_req SHALL be ignored, with no queuing.
REQ-032 In CLEAR, reads SHALL return current contents, so registers not yet swept still show old data; bypass SHALL be disabled.
REQ-033 Simultaneous clr_req with we or rsv_valid in IDLE: the write or reservation SHALL complete on that edge, and the sweep then erases it.
REQ-034 All index arithmetic SHALL be modulo DEPTH; cnt is ADDR_W+1 bits wide, or ADDR_W bits plus a terminal flag.

Reset
REQ-035 When rst=0 at a clk edge, all registers SHALL become 0, all busy bits 0, state IDLE, cnt 0 and clr_busy 0, all within that one edge.
REQ-036 Reset SHALL take priority over every other input, including a sweep in progress, which it aborts.
REQ-037 While rst=0, rd_data SHALL reflect stored contents, which are all 0 after the first edge, with bypass disabled.

Verification
REQ-038 Byte write: write 0x11223344 to r5 with be=1111, then 0xAABBCCDD with be=0101 -> r5 reads 0x11BB33DD; same-cycle read of the second write on port 1 shows 0x11BB33DD.
REQ-039 Zero register: write 0xFFFFFFFF to r0 and reserve r0 -> read r0 gives 0, rd_busy=0; repeat with ZERO_REG=0 -> read gives 0xFFFFFFFF.
REQ-040 Scoreboard: reserve r7, then read r7 -> rd_busy=1; write r7 -> busy=0 at the next edge; reserve and write r9 in the same cycle -> busy=1 and data updated.
REQ-041 Clear sweep: load r1..r31 = index, pulse clr_req -> clr_busy high for 32 cycles; a write to r3 during the sweep is dropped; afterwards all reads return 0 and all busy bits are 0.
REQ-042 Reset mid-sweep: assert rst=0 at sweep cycle 10 -> next edge clr_busy=0, all registers 0, state IDLE; a later write to r4 with value 0x5 reads back 0x5.
REQ-043 Parameter sweep: run with NRD=4, DATA_W=64, ADDR_W=3 -> four ports read distinct registers in the same cycle correctly; the clear sweep lasts 8 cycles.
